uart_send_bpm: RTL

- Transmits one 32-bit BPM value over the UART line as a 6-byte frame: 's' (0x73), BPM[31:24], BPM[23:16], BPM[15:8], BPM[7:0], 'e' (0x65).
- This is the exact framing uart_receive_bpm expects. The block is the sending end of the same link, used for loopback, a board-to-board BPM link and bench stimulus.
- Contains its own frame sequencer and 8N1 bit serializer; no external uart_tx is instantiated.

---
 rtl/uart_send_bpm.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_send_bpm.sv
// rtl/uart_send_bpm.sv - 8N1 sender of an 's' + 4 BPM bytes + 'e' frame (checksum byte: UART_SEND_BPM_CHECKSUM_EN)
`timescale 1ns/1ps
module uart_send_bpm #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_send_valid,
    input  logic [31:0] i_bpm_count,
    output logic        o_send_ready,
    output logic        o_uart_tx,
    output logic        o_tx_busy,
    output logic        o_tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] SER_IDLE  = 2'd0;
    localparam logic [1:0] SER_START = 2'd1;
    localparam logic [1:0] SER_DATA  = 2'd2;
    localparam logic [1:0] SER_STOP  = 2'd3;

    localparam logic [3:0] SEQ_IDLE = 4'd0;
    localparam logic [3:0] SEQ_SOM  = 4'd1;
    localparam logic [3:0] SEQ_B3   = 4'd2;
    localparam logic [3:0] SEQ_B2   = 4'd3;
    localparam logic [3:0] SEQ_B1   = 4'd4;
    localparam logic [3:0] SEQ_B0   = 4'd5;
    localparam logic [3:0] SEQ_EOM  = 4'd6;
    localparam logic [3:0] SEQ_DONE = 4'd7;
`ifdef UART_SEND_BPM_CHECKSUM_EN
    localparam logic [3:0] SEQ_CHK  = 4'd8;
`endif

    logic [3:0]       seq_q, seq_d;
    logic [1:0]       ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [3:0]       seq_nxt;

    function automatic logic [3:0] seq_next(input logic [3:0] s);
        case (s)
            SEQ_SOM: seq_next = SEQ_B3;
            SEQ_B3:  seq_next = SEQ_B2;
            SEQ_B2:  seq_next = SEQ_B1;
            SEQ_B1:  seq_next = SEQ_B0;
`ifdef UART_SEND_BPM_CHECKSUM_EN
            SEQ_B0:  seq_next = SEQ_CHK;
            SEQ_CHK: seq_next = SEQ_EOM;
`else
            SEQ_B0:  seq_next = SEQ_EOM;
`endif
            default: seq_next = SEQ_DONE;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [3:0] s, input logic [31:0] v);
        case (s)
            SEQ_B3:  byte_of = v[31:24];
            SEQ_B2:  byte_of = v[23:16];
            SEQ_B1:  byte_of = v[15:8];
            SEQ_B0:  byte_of = v[7:0];
`ifdef UART_SEND_BPM_CHECKSUM_EN
            SEQ_CHK: byte_of = v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
`endif
            SEQ_EOM: byte_of = 8'h65;
            default: byte_of = 8'h73;
        endcase
    endfunction

    assign accept  = i_send_valid & ready_q;
    assign seq_nxt = seq_next(seq_q);

    always_comb begin
        seq_d    = seq_q;
        ser_d    = ser_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (ser_q)
            SER_IDLE: begin
                if (seq_q == SEQ_DONE) begin
                    seq_d = SEQ_IDLE;
                end
                if (accept) begin
                    shadow_d = i_bpm_count;
                    seq_d    = SEQ_SOM;
                    ser_d    = SER_START;
                    cnt_d    = '0;
                    data_d   = 8'h73;
                    tx_d     = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            SER_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    ser_d = SER_DATA;
                    tx_d  = data_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SER_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        ser_d = SER_STOP;
                        tx_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Last stop-bit cycle: chain straight into the next byte's start bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    seq_d = seq_nxt;
                    if (seq_nxt == SEQ_DONE) begin
                        ser_d   = SER_IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        ser_d  = SER_START;
                        data_d = byte_of(seq_nxt, shadow_q);
                        tx_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_q    <= SEQ_IDLE;
            ser_q    <= SER_IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            data_q   <= 8'h00;
            shadow_q <= 32'h0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            ser_q    <= ser_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_send_ready = ready_q;
    assign o_uart_tx    = tx_q;
    assign o_tx_busy    = busy_q;
    assign o_tx_done    = done_q;

endmodule
